// File: rtl/aesha_out_serializer_pkg.sv
// Shared constants and types for the AESHA output serializer.
//   WORD_W / BLOCK_W     : output word and captured block widths
//   AES_WORDS            : words per AES result (full block)
//   KECCAK_WORDS         : words per Keccak result (256-bit digest in the low half)
//   ser_state_t          : serializer FSM states
package aesha_pkg;

    localparam int WORD_W       = 32;
    localparam int BLOCK_W      = 512;
    localparam int AES_WORDS    = 16;
    localparam int KECCAK_WORDS = 8;
    localparam int IDX_W        = $clog2(AES_WORDS);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } ser_state_t;

    // Index of the final word for a given result mode (0 = AES, 1 = Keccak).
    function automatic logic [IDX_W-1:0] last_index(input logic keccak);
        return keccak ? IDX_W'(KECCAK_WORDS - 1) : IDX_W'(AES_WORDS - 1);
    endfunction

endpackage

// File: rtl/aesha_out_serializer_if.sv
// Result-capture and word-stream signals of the AESHA output serializer.
//   i_done / i_aes_or_keccak / i_data : result pulse, mode and block from the core
//   o_valid / i_ready / o_word / o_last : word stream to the consumer
//   o_busy / o_overrun                : status
// modport slave  : the serializer itself
// modport master : the environment (core + consumer) around it
interface aesha_out_serializer_if;
    import aesha_pkg::*;

    logic               i_done;
    logic               i_aes_or_keccak;
    logic [BLOCK_W-1:0] i_data;
    logic               o_valid;
    logic               i_ready;
    logic [WORD_W-1:0]  o_word;
    logic               o_last;
    logic               o_busy;
    logic               o_overrun;

    modport slave (
        input  i_done, i_aes_or_keccak, i_data, i_ready,
        output o_valid, o_word, o_last, o_busy, o_overrun
    );

    modport master (
        output i_done, i_aes_or_keccak, i_data, i_ready,
        input  o_valid, o_word, o_last, o_busy, o_overrun
    );

endinterface

// File: rtl/aesha_out_serializer.sv
// AESHA output serializer: captures the 512-bit result on the core's done
// pulse and streams it out as 32-bit words, low word first, with o_last on
// the final word. A result arriving mid-drain is dropped and flagged in the
// sticky o_overrun; one arriving on the final handshake is taken seamlessly.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : result capture + word stream (aesha_out_serializer_if.slave)
// All outputs are registers; i_ready only steers register updates.
module aesha_out_serializer
    import aesha_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    aesha_out_serializer_if.slave bus
);

    ser_state_t         state;
    logic [BLOCK_W-1:0] blk;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   last_idx;
    logic               valid_q;
    logic [WORD_W-1:0]  word_q;
    logic               last_q;
    logic               overrun_q;

    logic             xfer;
    logic             final_xfer;
    logic             load;
    logic [IDX_W-1:0] idx_nxt;

    assign xfer       = valid_q && bus.i_ready;
    assign final_xfer = xfer && (idx == last_idx);
    // A new block is accepted when idle, or exactly as the last word leaves.
    assign load       = bus.i_done && ((state == IDLE) || final_xfer);
    assign idx_nxt    = idx + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            blk       <= '0;
            idx       <= '0;
            last_idx  <= '0;
            valid_q   <= 1'b0;
            word_q    <= '0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else if (load) begin
            state    <= DRAIN;
            blk      <= bus.i_data;
            idx      <= '0;
            last_idx <= last_index(bus.i_aes_or_keccak);
            valid_q  <= 1'b1;
            word_q   <= bus.i_data[WORD_W-1:0];
            last_q   <= 1'b0;
        end else if (state == DRAIN) begin
            if (bus.i_done) begin
                overrun_q <= 1'b1;
            end
            if (final_xfer) begin
                state   <= IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (xfer) begin
                // Pre-select the next word so o_word stays a plain register.
                idx    <= idx_nxt;
                word_q <= blk[idx_nxt*WORD_W +: WORD_W];
                last_q <= (idx_nxt == last_idx);
            end
        end
    end

    assign bus.o_valid   = valid_q;
    assign bus.o_word    = word_q;
    assign bus.o_last    = last_q;
    assign bus.o_busy    = (state == DRAIN);
    assign bus.o_overrun = overrun_q;

endmodule
